// File: rtl/bv8_sbox_back_column.sv
// bv8_sbox_back_column
//   Output stage of the masked AES S-box. Each share of the incoming byte is
//   mapped from the tower-field basis back to the polynomial basis, share 0
//   picks up the affine constant 0x63, and four consecutive bytes are packed
//   into one 32-bit column per share.
//
// Ports
//   in_clock   : clock, rising edge
//   in_reset   : synchronous reset, active low
//   in_valid   : upstream byte valid
//   in_ready   : block can take a byte this cycle
//   in_x       : masked byte per share, share s at [8s+7:8s]
//   out_valid  : complete column held
//   out_ready  : downstream takes the column
//   out_col    : column per share, share s at [32s+31:32s], byte k at [8k+7:8k]
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | cnt 0..3: collecting bytes, out_valid = 0
// FULL  | cnt 4: column presented, holds until out_ready at an edge

// Back basis change (tower field -> polynomial basis). Purely linear, so it
// is applied to each share independently without touching the masking.
module bv8_back_basis_fwd (
    input  logic [7:0] x,
    output logic [7:0] y
);
    assign y[0] = x[1] ^ x[4] ^ x[6];
    assign y[1] = x[1] ^ x[4] ^ x[5];
    assign y[2] = x[0] ^ x[2] ^ x[3] ^ x[5] ^ x[6];
    assign y[3] = x[3] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
    assign y[4] = x[3] ^ x[5] ^ x[7];
    assign y[5] = x[0] ^ x[6];
    assign y[6] = x[3] ^ x[7];
    assign y[7] = x[3] ^ x[5];
endmodule

module bv8_sbox_back_column #(
    parameter int NUM_SHARES = 2
) (
    input  logic                     in_clock,
    input  logic                     in_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SHARES*8-1:0]  in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_SHARES*32-1:0] out_col
);
    localparam logic [2:0] CNT_FULL = 3'd4;
    localparam logic [7:0] AFFINE_C = 8'h63;

    logic [2:0]                        cnt;
    logic [NUM_SHARES-1:0][31:0]       col;
    logic [NUM_SHARES-1:0][7:0]        y;
    logic                              full;
    logic                              accept;
    logic [1:0]                        slot;

    for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
        logic [7:0] b;
        bv8_back_basis_fwd u_basis (
            .x (in_x[8*s +: 8]),
            .y (b)
        );
        // Only share 0 carries the constant; the XOR of all shares then
        // gains exactly one 0x63.
        if (s == 0) begin : g_aff
            assign y[s] = b ^ AFFINE_C;
        end else begin : g_plain
            assign y[s] = b;
        end
    end

    assign full      = (cnt == CNT_FULL);
    assign in_ready  = !full || out_ready;
    assign accept    = in_valid && in_ready;
    // A byte arriving while the full column drains starts the next column.
    assign slot      = full ? 2'd0 : cnt[1:0];
    assign out_valid = full;
    assign out_col   = col;

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            cnt <= 3'd0;
            col <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_SHARES; i++) begin
                    col[i][{slot, 3'b000} +: 8] <= y[i];
                end
            end
            if (full && out_ready) begin
                cnt <= accept ? 3'd1 : 3'd0;
            end else if (accept) begin
                cnt <= cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_bv8_sbox_back_column.sv
module tb_bv8_sbox_back_column;
    logic        clk = 1'b0;
    logic        in_reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_x = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_col;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    logic [63:0] exp_q [$];
    logic [7:0]  part0 [$];
    logic [7:0]  part1 [$];

    bv8_sbox_back_column #(.NUM_SHARES(2)) dut (
        .in_clock  (clk),
        .in_reset  (in_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Image of basis vector e_i under the back basis change.
    function automatic logic [7:0] basis_col(input int i);
        case (i)
            0: return 8'h24;
            1: return 8'h03;
            2: return 8'h04;
            3: return 8'hDC;
            4: return 8'h0B;
            5: return 8'h9E;
            6: return 8'h2D;
            default: return 8'h58;
        endcase
    endfunction

    function automatic logic [7:0] sbox_share(input logic [7:0] x, input int s);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++)
            if (x[i]) r = r ^ basis_col(i);
        if (s == 0) r = r ^ 8'h63;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: tracks accepted bytes and completed columns.
    initial begin
        logic m_ready;
        forever begin
            @(negedge clk);
            #1;
            if (!in_reset) begin
                exp_q.delete();
                part0.delete();
                part1.delete();
            end else begin
                m_ready = (exp_q.size() == 0) || out_ready;
                if (started) chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
                if (in_valid && m_ready) begin
                    part0.push_back(sbox_share(in_x[7:0], 0));
                    part1.push_back(sbox_share(in_x[15:8], 1));
                    if (part0.size() == 4) begin
                        exp_q.push_back({part1[3], part1[2], part1[1], part1[0],
                                         part0[3], part0[2], part0[1], part0[0]});
                        part0.delete();
                        part1.delete();
                    end
                end
            end
        end
    end

    // Monitor: compares presented column against the scoreboard.
    initial begin
        wait (started);
        forever begin
            @(negedge clk);
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0) begin
                chk("out_col", out_col, exp_q[0]);
                if (in_reset && out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_x      = {b, a};
        out_ready = r;
    endtask

    task automatic wait_col(input string name, input logic [63:0] req);
        bit got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                chk(name, out_col, req);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s actual=no_column required=%h", name, req);
        end
    endtask

    initial begin
        logic [63:0] bp_col;
        logic [12:0] pattern;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_col", out_col, 64'd0);
        @(posedge clk);
        #1;
        started = 1'b1;
        in_reset = 1'b1;

        // All-zero bytes
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h00, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        wait_col("zero_col", 64'h00000000_63636363);

        // Masked zero
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h01, 8'h01, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        wait_col("masked_zero", 64'h24242424_47474747);

        // Byte order
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        drive(1'b1, 8'h01, 8'h00, 1'b1);
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        drive(1'b1, 8'h01, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        wait_col("byte_order", 64'h00000000_47634763);

        // Backpressure
        drive(1'b1, 8'h10, 8'h55, 1'b0);
        drive(1'b1, 8'h20, 8'h55, 1'b0);
        drive(1'b1, 8'h30, 8'h55, 1'b0);
        drive(1'b1, 8'h40, 8'h55, 1'b0);
        bp_col = {{4{sbox_share(8'h55, 1)}},
                  sbox_share(8'h40, 0), sbox_share(8'h30, 0),
                  sbox_share(8'h20, 0), sbox_share(8'h10, 0)};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hA5, 8'h3C, 1'b0);
            @(negedge clk);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold_col", out_col, bp_col);
        end
        drive(1'b1, 8'hA5, 8'h3C, 1'b1);
        @(negedge clk);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        drive(1'b1, 8'h11, 8'h00, 1'b1);
        drive(1'b1, 8'h22, 8'h00, 1'b1);
        drive(1'b1, 8'h33, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        wait_col("bp_slot0", {8'h00, 8'h00, 8'h00, sbox_share(8'h3C, 1),
                              sbox_share(8'h33, 0), sbox_share(8'h22, 0),
                              sbox_share(8'h11, 0), sbox_share(8'hA5, 0)});

        // Continuous streaming
        for (int i = 0; i < 13; i++) begin
            drive(i < 12, 8'($urandom), 8'($urandom), 1'b1);
            @(negedge clk);
            pattern[i] = out_valid;
        end
        chk("stream_pattern", {51'd0, pattern}, 64'h1110);

        // Reset mid-column
        drive(1'b1, 8'h5A, 8'hC3, 1'b1);
        drive(1'b1, 8'h7E, 8'h81, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_reset = 1'b0;
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h00, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        wait_col("after_reset", 64'h00000000_63636363);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0);
            in_reset = ($urandom_range(0, 79) != 0);
        end
        in_reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
